// File: rtl/maoin_ram_tester.sv
// Avalon-MM RAM self-test master: writes seed+i over a word window, then
// reads it back with up to MAX_PENDING reads in flight and checks each word.
module maoin_ram_tester #(
    parameter int ADDR_W      = 13,
    parameter int MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FIN} state_t;

    localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   num_q;
    logic [31:0]       seed_q;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   ridx;
    logic [3:0]        pending;

    logic              start_ok, wr_acc, rd_acc, rsp, mismatch, idx_last;
    logic [ADDR_W-1:0] idx_addr;

    assign avm_byteenable = 4'hF;

    always_comb begin
        // done high means the FSM is already back in IDLE; that start is dropped
        start_ok      = (state == S_IDLE) && start && !done;
        idx_addr      = base_q + idx[ADDR_W-1:0];
        idx_last      = (idx == num_q - 1'b1);
        avm_write     = (state == S_WRITE);
        avm_read      = (state == S_READ) && (pending < PEND_MAX) && (idx < num_q);
        avm_address   = (avm_write || avm_read) ? {idx_addr, 2'b00} : '0;
        avm_writedata = avm_write ? (seed_q + 32'(idx)) : '0;
        wr_acc        = avm_write && !avm_waitrequest;
        rd_acc        = avm_read && !avm_waitrequest;
        rsp           = ((state == S_READ) || (state == S_DRAIN)) && avm_readdatavalid;
        mismatch      = rsp && (avm_readdata != (seed_q + 32'(ridx)));

        state_nx = state;
        case (state)
            S_IDLE:  if (start_ok) state_nx = (num_words == '0) ? S_FIN : S_WRITE;
            S_WRITE: if (wr_acc && idx_last) state_nx = S_READ;
            S_READ:  if (rd_acc && idx_last) state_nx = S_DRAIN;
            S_DRAIN: if ((pending == '0) && (ridx == num_q)) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q         <= '0;
            num_q          <= '0;
            seed_q         <= '0;
            idx            <= '0;
            ridx           <= '0;
            pending        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                base_q         <= base_addr;
                num_q          <= num_words;
                seed_q         <= seed;
                idx            <= '0;
                ridx           <= '0;
                pending        <= '0;
                busy           <= 1'b1;
                pass           <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
            end
            if (wr_acc) idx <= idx_last ? '0 : idx + 1'b1;
            if (rd_acc) idx <= idx + 1'b1;
            // acceptance and a response in the same cycle cancel out
            if (rd_acc && !rsp)      pending <= pending + 1'b1;
            else if (!rd_acc && rsp) pending <= pending - 1'b1;
            if (rsp) ridx <= ridx + 1'b1;
            if (mismatch) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
                if (err_count == '0)       first_err_addr <= base_q + ridx[ADDR_W-1:0];
            end
            if (state == S_FIN) begin
                done <= 1'b1;
                busy <= 1'b0;
                pass <= (err_count == '0);
            end
        end
    end

endmodule
